// File: rtl/mem_port_arb.sv
// mem_port_arb -- shares the single MCB command/data port (memclk domain)
// between the display read engine and the left/right camera write engines.
//
// Ports:
//   memclk                 memory-side clock, all logic on the rising edge
//   rst                    asynchronous active-high reset
//   arb_on                 1 = new grants allowed, 0 = finish current grant then idle
//   rd_req/wr0_req/wr1_req level requests from the read, left and right engines
//   rd_donep/wr0_donep/wr1_donep  per-engine done (may stay high several cycles)
//   rd_memcon_en/wr0_memcon_en/wr1_memcon_en  registered one-hot grant enables
//   arb_state              owner code: 00 rd, 01 wr0, 10 wr1, 11 none
//   timeout_err            sticky, set when a grant is force-released
//   owner_last             code of the most recently released owner
//   dbg_state              FSM state (00 IDLE, 01 HOLD, 10 GAP)
//
// Handshake: an engine holds *_req while it has work. The grant is the level
// *_memcon_en, which stays high until the engine raises its *_donep (or the
// timeout fires). A request is not eligible while its own donep is still
// high, and after a release the port rests in GAP until the released
// owner's donep is low, so a lingering done never ends a later grant.
module mem_port_arb #(
  parameter int TIMEOUT = 4096,
  parameter int GAP     = 2,
  parameter int RD_PRIO = 1
) (
  input  logic       memclk,
  input  logic       rst,
  input  logic       arb_on,
  input  logic       rd_req,
  input  logic       wr0_req,
  input  logic       wr1_req,
  input  logic       rd_donep,
  input  logic       wr0_donep,
  input  logic       wr1_donep,
  output logic       rd_memcon_en,
  output logic       wr0_memcon_en,
  output logic       wr1_memcon_en,
  output logic [1:0] arb_state,
  output logic       timeout_err,
  output logic [1:0] owner_last,
  output logic [1:0] dbg_state
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int GW = $clog2(GAP + 1) + 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  // GAP occupies max(GAP,1) cycles; the IDLE cycle that follows is the
  // sampling cycle for the next grant.
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  localparam logic [1:0] C_RD   = 2'b00;
  localparam logic [1:0] C_WR0  = 2'b01;
  localparam logic [1:0] C_WR1  = 2'b10;
  localparam logic [1:0] C_NONE = 2'b11;
  localparam logic [1:0] PTR_RST = (RD_PRIO != 0) ? C_WR0 : C_RD;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_HOLD = 2'b01,
    S_GAP  = 2'b10
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [1:0]      r_owner, w_owner_nxt;
  logic [2:0]      r_en, w_en_nxt;
  logic [1:0]      r_arb, w_arb_nxt;
  logic            r_err, w_err_nxt;
  logic [1:0]      r_last, w_last_nxt;
  logic [1:0]      r_ptr, w_ptr_nxt;
  logic [TW-1:0]   r_to_cnt, w_to_nxt;
  logic [GW-1:0]   r_gap_cnt, w_gap_nxt;

  logic [2:0]      w_elig;
  logic [1:0]      w_sel;
  logic [1:0]      w_rr_idx;
  logic            w_own_done;
  logic            w_to_hit;
  logic            w_gap_done;
  logic            w_grant;
  logic            w_release;
  logic [1:0]      w_ptr_rel;

  // bit 0 = rd, bit 1 = wr0, bit 2 = wr1 (bit index equals owner code)
  assign w_elig = {wr1_req & ~wr1_donep, wr0_req & ~wr0_donep, rd_req & ~rd_donep};

  always_comb begin
    w_own_done = 1'b0;
    case (r_owner)
      C_RD:    w_own_done = rd_donep;
      C_WR0:   w_own_done = wr0_donep;
      C_WR1:   w_own_done = wr1_donep;
      default: w_own_done = 1'b0;
    endcase
  end

  assign w_to_hit   = (r_to_cnt == TO_LAST);
  assign w_gap_done = (r_gap_cnt >= GAP_LAST);
  assign w_grant    = (r_state == S_IDLE) && arb_on && (|w_elig);
  assign w_release  = (r_state == S_HOLD) && (w_own_done || w_to_hit);

  // Owner selection. With read priority the pointer names the preferred
  // writer; in round robin it names the first owner to try.
  always_comb begin
    w_sel    = C_RD;
    w_rr_idx = 2'b00;
    if (RD_PRIO != 0) begin
      if (w_elig[0])          w_sel = C_RD;
      else if (r_ptr == C_WR1) w_sel = w_elig[2] ? C_WR1 : C_WR0;
      else                     w_sel = w_elig[1] ? C_WR0 : C_WR1;
    end else begin
      // Walk from the farthest offset down so the nearest eligible wins.
      for (int k = 2; k >= 0; k--) begin
        w_rr_idx = 2'((int'(r_ptr) + k) % 3);
        if (w_elig[w_rr_idx]) w_sel = w_rr_idx;
      end
    end
  end

  always_comb begin
    w_ptr_rel = r_ptr;
    if (RD_PRIO != 0) begin
      if (r_owner == C_WR0)      w_ptr_rel = C_WR1;
      else if (r_owner == C_WR1) w_ptr_rel = C_WR0;
    end else begin
      case (r_owner)
        C_RD:    w_ptr_rel = C_WR0;
        C_WR0:   w_ptr_rel = C_WR1;
        default: w_ptr_rel = C_RD;
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge memclk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_owner   <= C_NONE;
      r_en      <= 3'b000;
      r_arb     <= C_NONE;
      r_err     <= 1'b0;
      r_last    <= C_NONE;
      r_ptr     <= PTR_RST;
      r_to_cnt  <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_en      <= w_en_nxt;
      r_arb     <= w_arb_nxt;
      r_err     <= w_err_nxt;
      r_last    <= w_last_nxt;
      r_ptr     <= w_ptr_nxt;
      r_to_cnt  <= w_to_nxt;
      r_gap_cnt <= w_gap_nxt;
    end
  end

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_HOLD;
      S_HOLD:  if (w_release) w_state_nxt = S_GAP;
      S_GAP:   if (w_gap_done && !w_own_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and counters
  always_comb begin
    w_owner_nxt = r_owner;
    w_en_nxt    = r_en;
    w_arb_nxt   = r_arb;
    w_err_nxt   = r_err;
    w_last_nxt  = r_last;
    w_ptr_nxt   = r_ptr;
    w_to_nxt    = r_to_cnt;
    w_gap_nxt   = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        w_to_nxt  = '0;
        w_gap_nxt = '0;
        if (w_grant) begin
          w_owner_nxt = w_sel;
          w_en_nxt    = 3'b001 << w_sel;
          w_arb_nxt   = w_sel;
        end
      end
      S_HOLD: begin
        if (w_release) begin
          w_en_nxt   = 3'b000;
          w_arb_nxt  = C_NONE;
          w_last_nxt = r_owner;
          w_ptr_nxt  = w_ptr_rel;
          w_gap_nxt  = '0;
          if (!w_own_done) w_err_nxt = 1'b1;
        end else begin
          w_to_nxt = r_to_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (!w_gap_done) w_gap_nxt = r_gap_cnt + 1'b1;
      end
      default: begin
        w_en_nxt  = 3'b000;
        w_arb_nxt = C_NONE;
      end
    endcase
  end

  assign rd_memcon_en  = r_en[0];
  assign wr0_memcon_en = r_en[1];
  assign wr1_memcon_en = r_en[2];
  assign arb_state     = r_arb;
  assign timeout_err   = r_err;
  assign owner_last    = r_last;
  assign dbg_state     = r_state;

endmodule
